// File: rtl/spi_rx.sv
// SPI receive deserialiser: synchronises sclk/cs/mosi, frames on active-low cs, shifts LSB first
// on falling sclk and queues good words in a small FIFO. Optional error counter: SPI_RX_ERR_CNT_EN.
module spi_rx #(
    parameter int DW         = 12,
    parameter int LEAD_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          cs,
    input  logic          mosi,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          busy,
    output logic          frame_err,
    output logic [7:0]    err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int LW = $clog2(LEAD_BITS + 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);
    localparam logic [LW-1:0] LEAD_LAST = LW'((LEAD_BITS > 0) ? LEAD_BITS - 1 : 0);
    localparam logic [AW:0]   DEPTH_P   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TAIL} state_t;

    logic sclk_m_q, sclk_s_q, sclk_d_q;
    logic cs_m_q, cs_s_q, cs_d_q;
    logic mosi_m_q, mosi_s_q;
    logic [1:0] warm_q, warm_d;
    logic armed_q, armed_d;

    state_t          state_q, state_d;
    logic [LW-1:0]   lead_cnt_q, lead_cnt_d;
    logic [BW-1:0]   bitcnt_q, bitcnt_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic            tail_seen_q, tail_seen_d;
    logic            long_q, long_d;
    logic            frame_err_q, frame_err_d;

    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic            fall, cs_fall, cs_rise;
    logic            push_req, reject, full, pop, push_ok, drop, err_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sclk_m_q, sclk_s_q, sclk_d_q} <= 3'b000;
            {cs_m_q, cs_s_q, cs_d_q}       <= 3'b111;
            {mosi_m_q, mosi_s_q}           <= 2'b00;
        end else begin
            {sclk_m_q, sclk_s_q, sclk_d_q} <= {sclk, sclk_m_q, sclk_s_q};
            {cs_m_q, cs_s_q, cs_d_q}       <= {cs, cs_m_q, cs_s_q};
            {mosi_m_q, mosi_s_q}           <= {mosi, mosi_m_q};
        end
    end

    assign fall    = sclk_d_q & ~sclk_s_q;
    assign cs_fall = cs_d_q & ~cs_s_q;
    assign cs_rise = ~cs_d_q & cs_s_q;

    // A frame may only start once cs_s has been seen high on real pin samples after reset,
    // so a cs held low across reset release does not open a frame.
    always_comb begin
        warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        armed_d = armed_q | ((warm_q == 2'd2) & cs_s_q);
    end

    always_comb begin
        state_d     = state_q;
        lead_cnt_d  = lead_cnt_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        tail_seen_d = tail_seen_q;
        long_d      = long_q;
        push_req    = 1'b0;
        reject      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    lead_cnt_d  = '0;
                    bitcnt_d    = '0;
                    tail_seen_d = 1'b0;
                    long_d      = 1'b0;
                    state_d     = (LEAD_BITS == 0) ? SHIFT : LEAD;
                end
            end
            LEAD: begin
                if (cs_rise) begin
                    reject  = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    lead_cnt_d = lead_cnt_q + LW'(1);
                    if (lead_cnt_q == LEAD_LAST) state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    reject  = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    shreg_d[bitcnt_q] = mosi_s_q;
                    bitcnt_d          = bitcnt_q + BW'(1);
                    if (bitcnt_q == BIT_LAST) state_d = TAIL;
                end
            end
            TAIL: begin
                // A long frame was already reported at its second tail fall; cs_rise just discards.
                if (cs_rise) begin
                    push_req = ~long_q;
                    state_d  = IDLE;
                end else if (fall && !long_q) begin
                    if (tail_seen_q) begin
                        long_d = 1'b1;
                        reject = 1'b1;
                    end else begin
                        tail_seen_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        rx_valid    = (count != '0);
        full        = (count == DEPTH_P);
        pop         = rx_valid & rx_ready;
        push_ok     = push_req & (~full | pop);
        drop        = push_req & full & ~pop;
        err_evt     = reject | drop;
        frame_err_d = err_evt;
        wr_ptr_d    = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d    = rd_ptr_q + (AW + 1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            lead_cnt_q  <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            tail_seen_q <= 1'b0;
            long_q      <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            lead_cnt_q  <= lead_cnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            tail_seen_q <= tail_seen_d;
            long_q      <= long_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // When full and popping in the same cycle, the write slot equals the slot being freed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
        end
    end

    assign rx_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;

`ifdef SPI_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    always_comb err_cnt_d = (err_evt && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'h00;
        else        err_cnt_q <= err_cnt_d;
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: frame-level driver, queue-based model checked every cycle,
// plus literal expectations per scenario.
module tb_spi_rx;
    localparam int DW    = 12;
    localparam int LEAD  = 1;
    localparam int DEPTH = 4;
    localparam int H     = 6;

    localparam int EV_START   = 0;
    localparam int EV_GOOD    = 1;
    localparam int EV_SHORT   = 2;
    localparam int EV_LONG    = 3;
    localparam int EV_DISCARD = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sclk = 1'b0, cs = 1'b0, mosi = 1'b0, rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic rx_valid, busy, frame_err;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    spi_rx #(.DW(DW), .LEAD_BITS(LEAD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    typedef struct {
        int            at;
        int            kind;
        logic [DW-1:0] w;
    } ev_t;

    int total = 0, bad = 0, cyc = 0, err_seen = 0;
    ev_t ev_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic exp_busy = 1'b0, exp_err = 1'b0;
    int exp_err_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_err_cnt_out();
`ifdef SPI_RX_ERR_CNT_EN
        return 32'(exp_err_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Model: a pin event driven after edge n is acted on at edge n+3 (2-flop sync + edge flop).
    always @(posedge clk) begin
        bit push, err, pop, was_full;
        logic [DW-1:0] pw;
        cyc = cyc + 1;
        if (!rst_n) begin
            exp_q.delete();
            ev_q.delete();
            exp_busy    = 1'b0;
            exp_err     = 1'b0;
            exp_err_cnt = 0;
        end else begin
            push = 1'b0;
            err  = 1'b0;
            pw   = '0;
            while (ev_q.size() > 0 && ev_q[0].at == cyc) begin
                case (ev_q[0].kind)
                    EV_START:   exp_busy = 1'b1;
                    EV_GOOD:    begin exp_busy = 1'b0; push = 1'b1; pw = ev_q[0].w; end
                    EV_SHORT:   begin exp_busy = 1'b0; err = 1'b1; end
                    EV_LONG:    err = 1'b1;
                    EV_DISCARD: exp_busy = 1'b0;
                    default:    ;
                endcase
                void'(ev_q.pop_front());
            end
            was_full = (exp_q.size() == DEPTH);
            pop      = rx_ready && (exp_q.size() > 0);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (was_full && !pop) err = 1'b1;
                else exp_q.push_back(pw);
            end
            exp_err = err;
            if (err && exp_err_cnt < 255) exp_err_cnt++;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (!rst_n) begin
                check("rst_rx_valid", 32'(rx_valid), 0);
                check("rst_rx_data", 32'(rx_data), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_frame_err", 32'(frame_err), 0);
                check("rst_err_cnt", 32'(err_cnt), 0);
            end else begin
                check("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q[0]));
                check("busy", 32'(busy), 32'(exp_busy));
                check("frame_err", 32'(frame_err), 32'(exp_err));
                check("err_cnt", 32'(err_cnt), exp_err_cnt_out());
                if (frame_err) err_seen++;
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sched(input int kind, input logic [DW-1:0] w);
        ev_t e;
        e.at   = cyc + 3;
        e.kind = kind;
        e.w    = w;
        ev_q.push_back(e);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input int ndata, input int ntail,
                              input bit pop_at_push, input bit chk_lat);
        @(negedge clk);
        cs = 1'b0;
        sched(EV_START, '0);
        wait_n(H);
        for (int i = 0; i < LEAD; i++) begin
            sclk = 1'b1; mosi = 1'b0; wait_n(H);
            sclk = 1'b0; wait_n(H);
        end
        for (int i = 0; i < ndata; i++) begin
            sclk = 1'b1; mosi = w[i]; wait_n(H);
            sclk = 1'b0; wait_n(H);
        end
        for (int i = 0; i < ntail; i++) begin
            sclk = 1'b1; mosi = 1'b0; wait_n(H);
            sclk = 1'b0;
            if (i == 1 && ndata == DW) sched(EV_LONG, '0);
            wait_n(H);
        end
        cs = 1'b1;
        if (ndata < DW)      sched(EV_SHORT, '0);
        else if (ntail >= 2) sched(EV_DISCARD, '0);
        else                 sched(EV_GOOD, w);
        if (pop_at_push) begin
            wait_n(2); rx_ready = 1'b1;
            wait_n(1); rx_ready = 1'b0;
        end
        if (chk_lat) begin
            wait_n(2);
            check("lat_before_k2", 32'(rx_valid), 0);
            wait_n(1);
            check("lat_after_k2_valid", 32'(rx_valid), 1);
            check("lat_after_k2_data", 32'(rx_data), 'hA5C);
        end
        wait_n(2 * H);
    endtask

    task automatic drain();
        got_q.delete();
        @(negedge clk);
        rx_ready = 1'b1;
        repeat (2 * DEPTH + 4) begin
            if (rx_valid) got_q.push_back(rx_data);
            @(negedge clk);
        end
        rx_ready = 1'b0;
        wait_n(2);
    endtask

    initial begin
        int e0;
        // Reset with cs low and sclk toggling
        rst_n = 1'b0; cs = 1'b0; sclk = 1'b0;
        repeat (12) begin @(negedge clk); sclk = ~sclk; end
        @(negedge clk);
        sclk = 1'b0; rst_n = 1'b1;
        repeat (6) begin wait_n(H); sclk = ~sclk; end
        sclk = 1'b0;
        wait_n(6);
        check("rel_no_push", 32'(rx_valid), 0);
        check("rel_not_busy", 32'(busy), 0);
        @(negedge clk);
        cs = 1'b1;
        wait_n(12);

        // Single frame, master timing
        e0 = err_seen;
        send_frame(12'hA5C, DW, 1, 1'b0, 1'b1);
        wait_n(4);
        check("single_data", 32'(rx_data), 'hA5C);
        check("single_valid", 32'(rx_valid), 1);
        check("single_busy", 32'(busy), 0);
        check("single_err_pulses", 32'(err_seen - e0), 0);
        drain();
        check("single_drain_n", 32'(got_q.size()), 1);
        if (got_q.size() == 1) check("single_drain_w", 32'(got_q[0]), 'hA5C);

        // Overflow: 5 frames, ready low
        e0 = err_seen;
        for (int v = 1; v <= 5; v++) send_frame(DW'(v), DW, 1, 1'b0, 1'b0);
        wait_n(4);
        check("ovf_err_pulses", 32'(err_seen - e0), 1);
`ifdef SPI_RX_ERR_CNT_EN
        check("ovf_err_cnt", 32'(err_cnt), 1);
`else
        check("ovf_err_cnt", 32'(err_cnt), 0);
`endif
        check("ovf_valid", 32'(rx_valid), 1);
        drain();
        check("ovf_drain_n", 32'(got_q.size()), 4);
        for (int i = 0; i < got_q.size() && i < 4; i++) check("ovf_drain_w", 32'(got_q[i]), 32'(i + 1));
        check("ovf_empty", 32'(rx_valid), 0);

        // Full plus simultaneous pop
        e0 = err_seen;
        send_frame(12'h111, DW, 1, 1'b0, 1'b0);
        send_frame(12'h222, DW, 1, 1'b0, 1'b0);
        send_frame(12'h333, DW, 1, 1'b0, 1'b0);
        send_frame(12'h444, DW, 1, 1'b0, 1'b0);
        send_frame(12'h7E1, DW, 1, 1'b1, 1'b0);
        check("fullpop_err_pulses", 32'(err_seen - e0), 0);
        drain();
        check("fullpop_drain_n", 32'(got_q.size()), 4);
        if (got_q.size() == 4) begin
            check("fullpop_first", 32'(got_q[0]), 'h222);
            check("fullpop_third", 32'(got_q[2]), 'h444);
            check("fullpop_last", 32'(got_q[3]), 'h7E1);
        end

        // Short frame then a good frame
        e0 = err_seen;
        send_frame(12'h3C3, 6, 0, 1'b0, 1'b0);
        wait_n(4);
        check("short_no_push", 32'(rx_valid), 0);
        check("short_err_pulses", 32'(err_seen - e0), 1);
        check("short_busy", 32'(busy), 0);
        send_frame(12'hFFF, DW, 1, 1'b0, 1'b0);
        drain();
        check("after_short_n", 32'(got_q.size()), 1);
        if (got_q.size() == 1) check("after_short_w", 32'(got_q[0]), 'hFFF);

        // Long frame: 3 tail falls
        e0 = err_seen;
        send_frame(12'h5A5, DW, 3, 1'b0, 1'b0);
        wait_n(4);
        check("long_no_push", 32'(rx_valid), 0);
        check("long_err_pulses", 32'(err_seen - e0), 1);
        check("long_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
